// File: rtl/proj_ctrl_pkg.sv
// Shared types and helpers for the projection-memory controller.
// Optional bank1 rotation is enabled by defining PROJ_ROTATE_EN.
package proj_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Words per bank: the hypervector is split across two banks of in_width-bit words.
  function automatic int unsigned proj_depth(input int unsigned dhv_size,
                                             input int unsigned in_width);
    return dhv_size / (2 * in_width);
  endfunction

endpackage

// File: rtl/proj_addr_gen.sv
// Scan address counter with last-address detect; under PROJ_ROTATE_EN the
// bank1 address is offset by a sampled rotation, modulo the bank depth.
module proj_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 125
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  adv_i,
`ifdef PROJ_ROTATE_EN
  input  logic [ADDR_WIDTH-1:0] rot_i,
`endif
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  assign last_o = (ptr_q == LAST_ADDR);
  assign ptr_o  = ptr_q;

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (start_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = last_o ? '0 : ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef PROJ_ROTATE_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] rot_q, rot_d;
  logic [ADDR_WIDTH:0]   sum;

  always_comb begin
    rot_d = rot_q;
    if (start_i) begin
      // An out-of-range rotation collapses to identity rather than aliasing.
      rot_d = ({1'b0, rot_i} >= DEPTH_W) ? '0 : rot_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rot_q <= '0;
    end else begin
      rot_q <= rot_d;
    end
  end

  // Both operands are below DEPTH, so one conditional subtract wraps the sum.
  assign sum     = {1'b0, ptr_q} + {1'b0, rot_q};
  assign addr1_o = (sum >= DEPTH_W) ? ADDR_WIDTH'(sum - DEPTH_W) : sum[ADDR_WIDTH-1:0];
`else
  assign addr1_o = ptr_q;
`endif

endmodule

// File: rtl/proj_mem_controller.sv
// Load/scan sequencer for the two-bank projection memory feeding the HD encoder.
// Defining PROJ_ROTATE_EN adds rot_shift and a rotated bank1 scan address.
module proj_mem_controller
  import proj_ctrl_pkg::*;
#(
  parameter int Dhv_SIZE   = 4000,
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [2*IN_WIDTH-1:0] load_data,
  input  logic                  reload,
  input  logic                  scan_start,
`ifdef PROJ_ROTATE_EN
  input  logic [ADDR_WIDTH-1:0] rot_shift,
`endif
  output logic                  mem_we,
  output logic [2*IN_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [IN_WIDTH-1:0]   mem_rdata0,
  input  logic [IN_WIDTH-1:0]   mem_rdata1,
  output logic                  loaded,
  output logic                  scan_busy,
  output logic                  out_valid,
  output logic [IN_WIDTH-1:0]   out_data0,
  output logic [IN_WIDTH-1:0]   out_data1,
  output logic                  out_last
);

  localparam int DEPTH = int'(proj_depth(Dhv_SIZE, IN_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic                  loaded_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic                  rd_last;
  logic                  scan_go;
  logic                  in_scan;

  assign in_scan = (state_q == SCAN);
  // reload wins over a simultaneous scan_start in READY.
  assign scan_go = (state_q == READY) && scan_start && !reload;

  proj_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .start_i(scan_go),
    .adv_i  (in_scan),
`ifdef PROJ_ROTATE_EN
    .rot_i  (rot_shift),
`endif
    .ptr_o  (rd_ptr),
    .addr1_o(rd_addr1),
    .last_o (rd_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= in_scan;
      out_last_q  <= in_scan && rd_last;
      case (state_q)
        LOAD: begin
          if (load_valid) begin
            if (wr_ptr_q == WR_LAST) begin
              wr_ptr_q <= '0;
              loaded_q <= 1'b1;
              state_q  <= READY;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
        READY: begin
          if (reload) begin
            loaded_q <= 1'b0;
            state_q  <= LOAD;
          end else if (scan_start) begin
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (rd_last) state_q <= DRAIN;
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          state_q <= READY;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign load_ready = (state_q == LOAD);
  assign mem_we     = load_valid && load_ready;
  assign mem_wdata  = load_data;

  always_comb begin
    mem_addr0 = '0;
    mem_addr1 = '0;
    if (state_q == LOAD) begin
      mem_addr0 = wr_ptr_q;
      mem_addr1 = wr_ptr_q;
    end else if (in_scan) begin
      mem_addr0 = rd_ptr;
      mem_addr1 = rd_addr1;
    end
  end

  assign loaded    = loaded_q;
  assign scan_busy = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  // Read data arrives one cycle after its address, in step with out_valid.
  assign out_data0 = out_valid_q ? mem_rdata0 : '0;
  assign out_data1 = out_valid_q ? mem_rdata1 : '0;

endmodule

// File: tb/tb_proj_mem_controller.sv
// Directed self-checking bench for proj_mem_controller with a two-bank memory
// model; rotation cases run when PROJ_ROTATE_EN is defined.
module tb_proj_mem_controller;

  localparam int DEPTH = 125;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        reload;
  logic        scan_start;
`ifdef PROJ_ROTATE_EN
  logic [7:0]  rot_shift;
`endif
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_addr0;
  logic [7:0]  mem_addr1;
  logic [15:0] mem_rdata0;
  logic [15:0] mem_rdata1;
  logic        loaded;
  logic        scan_busy;
  logic        out_valid;
  logic [15:0] out_data0;
  logic [15:0] out_data1;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;
  int we_exp   = 0;

  always #5 clk = ~clk;

  proj_mem_controller dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .reload    (reload),
    .scan_start(scan_start),
`ifdef PROJ_ROTATE_EN
    .rot_shift (rot_shift),
`endif
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_addr0 (mem_addr0),
    .mem_addr1 (mem_addr1),
    .mem_rdata0(mem_rdata0),
    .mem_rdata1(mem_rdata1),
    .loaded    (loaded),
    .scan_busy (scan_busy),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_last  (out_last)
  );

  // NOTE: the bank arrays are deliberately never reset; the controller's reset
  // must leave stored projection words intact, just like real SRAM.
  logic [15:0] bank0 [0:255];
  logic [15:0] bank1 [0:255];

  always @(posedge clk) begin
    if (mem_we) begin
      bank0[mem_addr0] <= mem_wdata[15:0];
      bank1[mem_addr1] <= mem_wdata[31:16];
    end
    mem_rdata0 <= bank0[mem_addr0];
    mem_rdata1 <= bank1[mem_addr1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Every write must land on the next sequential address with pair data (2n, 2n+1).
  always @(negedge clk) begin
    if (mem_we) begin
      check("we_addr0", 64'(mem_addr0), 64'(we_exp));
      check("we_addr1", 64'(mem_addr1), 64'(we_exp));
      check("we_data", 64'(mem_wdata), {32'd0, 16'(2 * we_exp + 1), 16'(2 * we_exp)});
      we_exp++;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},     64'(mem_we),     64'd0);
    check({tag, "_addr0"},  64'(mem_addr0),  64'd0);
    check({tag, "_addr1"},  64'(mem_addr1),  64'd0);
    check({tag, "_flags"},  64'({loaded, scan_busy, out_valid, out_last}), 64'd0);
    check({tag, "_data"},   64'({out_data0, out_data1}), 64'd0);
    check({tag, "_ready"},  64'(load_ready), 64'd1);
  endtask

  // Drives count pairs; with gaps, load_valid drops every third cycle.
  task automatic load_pairs(input int count, input bit gaps);
    int n = 0;
    int c = 0;
    while (n < count) begin
      @(posedge clk); #1;
      if (gaps && (c % 3 == 2)) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data  = {16'(2 * n + 1), 16'(2 * n)};
        n++;
      end
      c++;
    end
    @(negedge clk);
    check("loaded_pre", 64'(loaded), 64'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Scan with optional illegal requests: reload+scan_start mid-scan and scan_start in DRAIN.
  task automatic run_scan(input int rot, input bit inject);
    int          r;
    int          k;
    logic        e_busy, e_valid, e_last;
    logic [7:0]  e_a0, e_a1;
    logic [15:0] e_d0, e_d1;
    r = (rot < DEPTH) ? rot : 0;
`ifdef PROJ_ROTATE_EN
    rot_shift = 8'(rot);
`else
    r = 0;
`endif
    @(posedge clk); #1;
    scan_start = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      @(posedge clk); #1;
      scan_start = inject && (i == 50 || i == 126);
      reload     = inject && (i == 50);
      @(negedge clk);
      k       = i - 2;
      e_busy  = (i <= DEPTH + 1);
      e_valid = (i >= 2) && (i <= DEPTH + 1);
      e_last  = (i == DEPTH + 1);
      e_a0    = (i <= DEPTH) ? 8'(i - 1) : 8'd0;
      e_a1    = (i <= DEPTH) ? 8'((i - 1 + r) % DEPTH) : 8'd0;
      e_d0    = e_valid ? 16'(2 * k) : 16'd0;
      e_d1    = e_valid ? 16'(2 * ((k + r) % DEPTH) + 1) : 16'd0;
      check($sformatf("scan_r%0d_c%0d", rot, i),
            {13'd0, scan_busy, out_valid, out_last, mem_addr0, mem_addr1, out_data0, out_data1},
            {13'd0, e_busy, e_valid, e_last, e_a0, e_a1, e_d0, e_d1});
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    reload     = 1'b0;
    scan_start = 1'b0;
`ifdef PROJ_ROTATE_EN
    rot_shift  = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // scan_start before anything is loaded must not start address activity.
    @(posedge clk); #1;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    @(negedge clk);
    check("early_scan_busy", 64'(scan_busy), 64'd0);
    check("early_scan_ready", 64'(load_ready), 64'd1);
    check("early_scan_addr", 64'(mem_addr0), 64'd0);

    // Partial load, then an asynchronous reset mid-cycle.
    load_pairs(40, 1'b0);
    @(negedge clk);
    check("partial_we_count", 64'(we_exp), 64'd40);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = 32'hdead_beef;
    #2;
    reset      = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset  = 1'b1;
    we_exp = 0;

    // Full load with gaps must restart at address 0.
    load_pairs(DEPTH, 1'b1);
    @(negedge clk);
    check("load_we_count", 64'(we_exp), 64'(DEPTH));
    check("loaded_post", 64'(loaded), 64'd1);
    check("ready_post", 64'(load_ready), 64'd0);
    @(posedge clk); #1;
    load_valid = 1'b1;
    @(negedge clk);
    check("ready_no_we", 64'(mem_we), 64'd0);
    check("ready_addr", 64'(mem_addr0), 64'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;

    run_scan(0, 1'b1);
    check("scan_keeps_loaded", 64'(loaded), 64'd1);
`ifdef PROJ_ROTATE_EN
    run_scan(3, 1'b0);
    run_scan(200, 1'b0);
`else
    run_scan(0, 1'b0);
`endif

    // reload beats scan_start when both arrive in READY.
    @(posedge clk); #1;
    reload     = 1'b1;
    scan_start = 1'b1;
    @(posedge clk); #1;
    reload     = 1'b0;
    scan_start = 1'b0;
    @(negedge clk);
    check("reload_loaded", 64'(loaded), 64'd0);
    check("reload_ready", 64'(load_ready), 64'd1);
    check("reload_busy", 64'(scan_busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("reload_busy2", 64'(scan_busy), 64'd0);
    check("reload_addr", 64'(mem_addr0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
